// File: rtl/sparhixcel_pkg.sv
// sparhixcel_pkg: shared systolic-array constants and weight-load FSM states
package sparhixcel_pkg;
    localparam int N_ROWS_ARRAY  = 4;
    localparam int N_COLS_ARRAY  = 4;
    localparam int N             = 3;
    localparam int F_WIDTH       = 8;
    localparam int SEL_WIDTH     = $clog2(N);
    localparam int NUM_COL_WIDTH = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} wls_state_t;
endpackage

// File: rtl/pe_index_counter.sv
// pe_index_counter: nested tap/column/row walker with programmable tap limit
module pe_index_counter #(
    parameter int N_ROWS    = 4,
    parameter int N_COLS    = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic                      en_i,
    input  logic [SEL_WIDTH-1:0]      k_max_i,
    output logic [SEL_WIDTH-1:0]      k_o,
    output logic [$clog2(N_COLS)-1:0] c_o,
    output logic [$clog2(N_ROWS)-1:0] r_o,
    output logic                      last_o
);
    localparam int CW = $clog2(N_COLS);
    localparam int RW = $clog2(N_ROWS);
    logic [SEL_WIDTH-1:0] k_q, k_d;
    logic [CW-1:0]        c_q, c_d;
    logic [RW-1:0]        r_q, r_d;
    logic                 k_wrap, c_wrap, r_wrap;
    always_comb begin
        k_wrap = k_q == k_max_i;
        c_wrap = c_q == CW'(N_COLS - 1);
        r_wrap = r_q == RW'(N_ROWS - 1);
        k_d    = clr_i ? '0 : !en_i ? k_q : k_wrap ? '0 : k_q + 1'b1;
        c_d    = clr_i ? '0 : !(en_i && k_wrap) ? c_q : c_wrap ? '0 : c_q + 1'b1;
        r_d    = clr_i ? '0 : !(en_i && k_wrap && c_wrap) ? r_q : r_wrap ? '0 : r_q + 1'b1;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            k_q <= '0;
            c_q <= '0;
            r_q <= '0;
        end else begin
            k_q <= k_d;
            c_q <= c_d;
            r_q <= r_d;
        end
    end
    assign k_o    = k_q;
    assign c_o    = c_q;
    assign r_o    = r_q;
    assign last_o = k_wrap && c_wrap && r_wrap;
endmodule

// File: rtl/weight_load_sequencer.sv
// weight_load_sequencer: fetches filter taps from weight memory and strobes them into each PE
module weight_load_sequencer #(
    parameter int N_ROWS_ARRAY  = sparhixcel_pkg::N_ROWS_ARRAY,
    parameter int N_COLS_ARRAY  = sparhixcel_pkg::N_COLS_ARRAY,
    parameter int F_WIDTH       = sparhixcel_pkg::F_WIDTH,
    parameter int N             = sparhixcel_pkg::N,
    parameter int SEL_WIDTH     = $clog2(N),
    parameter int NUM_COL_WIDTH = $clog2(N + 1),
    parameter int W_ADDRS_WIDTH = 10
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic [NUM_COL_WIDTH-1:0]        filter_size_i,
    input  logic [W_ADDRS_WIDTH-1:0]        base_addrs_i,
    output logic                            mem_rd_o,
    output logic [W_ADDRS_WIDTH-1:0]        mem_addrs_o,
    input  logic [F_WIDTH-1:0]              mem_data_i,
    input  logic                            mem_valid_i,
    output logic [F_WIDTH-1:0]              f_weight_o,
    output logic                            load_o,
    output logic [SEL_WIDTH-1:0]            f_sel_o,
    output logic [$clog2(N_ROWS_ARRAY)-1:0] row_num_o,
    output logic [$clog2(N_COLS_ARRAY)-1:0] column_num_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o
);
    import sparhixcel_pkg::*;
    localparam int RW = $clog2(N_ROWS_ARRAY);
    localparam int CW = $clog2(N_COLS_ARRAY);
    wls_state_t                 state_q, state_d;
    logic [NUM_COL_WIDTH-1:0]   fs_q, fs_d;
    logic [W_ADDRS_WIDTH-1:0]   base_q, base_d, count_q, count_d;
    logic [F_WIDTH-1:0]         weight_q, weight_d;
    logic [SEL_WIDTH-1:0]       sel_q, sel_d, k;
    logic [RW-1:0]              row_q, row_d, r;
    logic [CW-1:0]              col_q, col_d, c;
    logic                       load_q, load_d, done_q, done_d, err_q, err_d;
    logic                       cnt_clr, cnt_en, last, legal;
    pe_index_counter #(
        .N_ROWS    (N_ROWS_ARRAY),
        .N_COLS    (N_COLS_ARRAY),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_idx (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .k_max_i (SEL_WIDTH'(fs_q - 1'b1)),
        .k_o     (k),
        .c_o     (c),
        .r_o     (r),
        .last_o  (last)
    );
    assign legal = filter_size_i != '0 && filter_size_i <= NUM_COL_WIDTH'(N);
    always_comb begin
        state_d  = state_q;
        fs_d     = fs_q;
        base_d   = base_q;
        count_d  = count_q;
        weight_d = weight_q;
        sel_d    = sel_q;
        row_d    = row_q;
        col_d    = col_q;
        load_d   = 1'b0;
        err_d    = 1'b0;
        done_d   = state_q == DONE;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                if (legal) begin
                    fs_d    = filter_size_i;
                    base_d  = base_addrs_i;
                    count_d = '0;
                    cnt_clr = 1'b1;
                    state_d = REQ;
                end else begin
                    err_d = 1'b1;
                end
            end
            REQ: state_d = WAIT;
            WAIT: if (mem_valid_i) begin
                weight_d = mem_data_i;
                sel_d    = k;
                row_d    = r;
                col_d    = c;
                load_d   = 1'b1;
                count_d  = count_q + 1'b1;
                cnt_en   = 1'b1;
                state_d  = last ? DONE : REQ;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            fs_q     <= '0;
            base_q   <= '0;
            count_q  <= '0;
            weight_q <= '0;
            sel_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            load_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fs_q     <= fs_d;
            base_q   <= base_d;
            count_q  <= count_d;
            weight_q <= weight_d;
            sel_q    <= sel_d;
            row_q    <= row_d;
            col_q    <= col_d;
            load_q   <= load_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end
    assign mem_rd_o     = state_q == REQ;
    assign mem_addrs_o  = base_q + count_q;
    assign busy_o       = state_q != IDLE;
    assign f_weight_o   = weight_q;
    assign load_o       = load_q;
    assign f_sel_o      = sel_q;
    assign row_num_o    = row_q;
    assign column_num_o = col_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_weight_load_sequencer.sv
// tb_weight_load_sequencer: scoreboard bench with a fixed-latency weight memory model
module tb_weight_load_sequencer;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [1:0] filter_size_i = '0;
    logic [9:0] base_addrs_i = '0;
    logic       mem_rd_o;
    logic [9:0] mem_addrs_o;
    logic [7:0] mem_data_i = '0;
    logic       mem_valid_i = 1'b0;
    logic [7:0] f_weight_o;
    logic       load_o;
    logic [1:0] f_sel_o, row_num_o, column_num_o;
    logic       busy_o, done_o, err_o;

    typedef struct {logic [7:0] w; logic [1:0] k, c, r;} ld_t;
    ld_t        exp_ld[$];
    logic [9:0] exp_addr[$];
    int         compared = 0, mismatched = 0, n_loads = 0, lat = 1;
    bit         spur_req = 0;
    logic       pv[8];
    logic [7:0] pd[8];

    weight_load_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .filter_size_i(filter_size_i),
        .base_addrs_i(base_addrs_i), .mem_rd_o(mem_rd_o), .mem_addrs_o(mem_addrs_o),
        .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i), .f_weight_o(f_weight_o),
        .load_o(load_o), .f_sel_o(f_sel_o), .row_num_o(row_num_o), .column_num_o(column_num_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory returns data = address[7:0], lat cycles after the read cycle
    initial begin
        for (int i = 0; i < 8; i++) begin pv[i] = 1'b0; pd[i] = '0; end
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                for (int i = 0; i < 8; i++) pv[i] = 1'b0;
                mem_valid_i = 1'b0;
            end else begin
                mem_valid_i = pv[0];
                mem_data_i  = pd[0];
                for (int i = 0; i < 7; i++) begin pv[i] = pv[i+1]; pd[i] = pd[i+1]; end
                pv[7] = 1'b0;
                if (mem_rd_o) begin
                    pv[lat-1] = 1'b1;
                    pd[lat-1] = mem_addrs_o[7:0];
                    if (spur_req) begin
                        mem_valid_i = 1'b1;
                        mem_data_i  = 8'hEE;
                        spur_req    = 0;
                    end
                end
            end
        end
    end

    initial begin
        ld_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (mem_rd_o) begin
                    check("rd_expected", 32'(exp_addr.size() != 0), 1);
                    if (exp_addr.size() != 0) check("addr", 32'(mem_addrs_o), 32'(exp_addr.pop_front()));
                end
                if (load_o) begin
                    n_loads++;
                    check("ld_expected", 32'(exp_ld.size() != 0), 1);
                    if (exp_ld.size() != 0) begin
                        e = exp_ld.pop_front();
                        check("weight", 32'(f_weight_o), 32'(e.w));
                        check("f_sel", 32'(f_sel_o), 32'(e.k));
                        check("col", 32'(column_num_o), 32'(e.c));
                        check("row", 32'(row_num_o), 32'(e.r));
                    end
                end
            end
        end
    end

    task automatic push_exp(input int fs, input int base);
        logic [9:0] a;
        ld_t        e;
        for (int i = 0; i < 16 * fs; i++) begin
            a = 10'(base + i);
            exp_addr.push_back(a);
            e.w = a[7:0];
            e.k = 2'(i % fs);
            e.c = 2'((i / fs) % 4);
            e.r = 2'(i / (fs * 4));
            exp_ld.push_back(e);
        end
    endtask

    task automatic start_pulse(input int fs, input int base, input bit hold);
        @(negedge clk_i);
        start_i       = 1'b1;
        filter_size_i = 2'(fs);
        base_addrs_i  = 10'(base);
        @(posedge clk_i);
        #1;
        if (!hold) start_i = 1'b0;
    endtask

    task automatic wait_done(input int exp_n, input int n0, input bit poke);
        int n;
        n = n0;
        do begin
            @(negedge clk_i);
            n++;
            if (n == 1) check("busy_c1", 32'(busy_o), 1);
            if (poke && n == 10) begin start_i = 1'b1; filter_size_i = 2'd1; base_addrs_i = 10'd999; end
            if (poke && n == 11) start_i = 1'b0;
            if (poke && n == 20) spur_req = 1;
        end while (!done_o && n < 3000);
        check("done_cycle", 32'(n), 32'(exp_n));
        check("busy_at_done", 32'(busy_o), 0);
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_outs"}, 32'({mem_rd_o, mem_addrs_o, f_weight_o, load_o, f_sel_o,
              row_num_o, column_num_o, done_o, err_o}), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_ld_left"}, 32'(exp_ld.size()), 0);
        check({tag, "_rd_left"}, 32'(exp_addr.size()), 0);
    endtask

    task automatic illegal_start(input logic [1:0] fs);
        @(negedge clk_i);
        start_i       = 1'b1;
        filter_size_i = fs;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        @(negedge clk_i);
        check("err_pulse", 32'(err_o), 1);
        check("err_busy", 32'(busy_o), 0);
        check("err_rd", 32'(mem_rd_o), 0);
        @(negedge clk_i);
        check("err_clear", 32'(err_o), 0);
        check("err_busy2", 32'(busy_o), 0);
    endtask

    initial begin
        int l0, n;
        repeat (3) @(negedge clk_i);
        check_idle_outs("reset");
        rst_i = 1'b0;

        lat = 1;
        push_exp(3, 0);
        start_pulse(3, 0, 0);
        wait_done(98, 0, 0);
        check_drained("fs3");

        lat = 3;
        push_exp(1, 1020);
        start_pulse(1, 1020, 0);
        wait_done(66, 0, 0);
        check_drained("wrap");

        illegal_start(2'd0);
        illegal_start(2'(4)); // 4 does not fit the 2-bit size field and arrives as 0

        lat = 1;
        push_exp(2, 10);
        start_pulse(2, 10, 0);
        wait_done(66, 0, 1);
        check_drained("poke");

        push_exp(3, 0);
        start_pulse(3, 0, 0);
        l0 = n_loads;
        n  = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!(n_loads == l0 + 20 && busy_o && !mem_rd_o) && n < 200);
        check("reach_word20", 32'(n_loads - l0), 20);
        rst_i = 1'b1;
        #1;
        check_idle_outs("midrst");
        exp_ld.delete();
        exp_addr.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        push_exp(3, 5);
        start_pulse(3, 5, 0);
        wait_done(98, 0, 0);
        check_drained("restart");

        push_exp(1, 100);
        push_exp(1, 200);
        start_pulse(1, 100, 1);
        base_addrs_i = 10'd200;
        wait_done(34, 0, 0);
        @(negedge clk_i);
        check("b2b_busy", 32'(busy_o), 1);
        check("b2b_rd", 32'(mem_rd_o), 1);
        start_i = 1'b0;
        wait_done(34, 1, 0);
        check_drained("b2b");

        repeat (3) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/weight_load_sequencer.md
# weight_load_sequencer

Sequences the weight-load phase of the systolic array. On a start request from the array controller it reads one filter tap per cycle-group from the weight memory and drives the array's per-PE load strobe, filter-select, row and column indices, walking every PE in a fixed order. It sits between the weight memory and `systolic_array`, and reports `busy`/`done`/`err` back to `SA_controller`.

## Interface
Parameters:
- N_ROWS_ARRAY, 4, array rows
- N_COLS_ARRAY, 4, array columns
- F_WIDTH, 8, weight word width
- N, 3, maximum filter size (taps per PE)
- SEL_WIDTH, $clog2(N), filter-select width
- NUM_COL_WIDTH, $clog2(N+1), filter-size field width
- W_ADDRS_WIDTH, 10, weight memory address width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin load; sampled in IDLE only
- filter_size_i  in  NUM_COL_WIDTH  taps per PE, legal 1..N, latched at start
- base_addrs_i  in  W_ADDRS_WIDTH  first weight address, latched at start
- mem_rd_o  out  1  one-cycle read request
- mem_addrs_o  out  W_ADDRS_WIDTH  read address, valid with mem_rd_o
- mem_data_i  in  F_WIDTH  read data
- mem_valid_i  in  1  read data valid, latency L ≥ 1 after mem_rd_o
- f_weight_o  out  F_WIDTH  weight to array
- load_o  out  1  one-cycle load strobe to array
- f_sel_o  out  SEL_WIDTH  tap index k
- row_num_o  out  $clog2(N_ROWS_ARRAY)  PE row r
- column_num_o  out  $clog2(N_COLS_ARRAY)  PE column c
- busy_o  out  1  high from start acceptance to done
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle illegal filter-size pulse

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on start_i with filter_size_i in 1..N, latch size and base, clear k/c/r and count, go REQ, busy_o=1. If filter_size_i is 0 or >N, pulse err_o next cycle, issue no reads, stay IDLE.
- REQ: mem_rd_o=1 for one cycle, mem_addrs_o = base + count (mod 2^W_ADDRS_WIDTH), then go WAIT.
- WAIT: hold until mem_valid_i. Then register f_weight_o=mem_data_i, f_sel_o=k, row_num_o=r, column_num_o=c, pulse load_o, and increment count. If this is the last word (k=fs-1, c=N_COLS_ARRAY-1, r=N_ROWS_ARRAY-1), go DONE. Otherwise go REQ.
- Index order: k fastest, then c, then r. k wraps at fs-1 and bumps c. c wraps at N_COLS_ARRAY-1 and bumps r.
- DONE: pulse done_o, clear busy_o, return IDLE.
- Total words = N_ROWS_ARRAY·N_COLS_ARRAY·fs.
- Ignore start_i while busy.
- Ignore mem_valid_i outside WAIT; no data is captured.
- f_weight_o and the indices hold their last values between load_o pulses.
- Reset (any time, including mid-load): state IDLE. All outputs 0: mem_rd_o, mem_addrs_o, f_weight_o, load_o, f_sel_o, row_num_o, column_num_o, busy_o, done_o, err_o. Counters cleared; in-flight memory data discarded.

## Timing
- Start sampled at edge 0. busy_o=1 and first mem_rd_o in cycle 1.
- A read in cycle t gets valid in cycle t+L. load_o and the next mem_rd_o occur in cycle t+L+1, so the period is L+1 cycles per weight.
- Last load_o in cycle 1+W(L+1), where W = total words. done_o in the following cycle, with busy_o low in that same cycle.
- Example: 4×4 array, fs=3, L=1 → W=48, last load cycle 97, done cycle 98.
- err_o in cycle 1 after an illegal start. busy_o stays 0.
- A new start is accepted in the cycle after done_o.

## Structure
- Shared package sparhixcel_pkg holds the array and width constants (N_ROWS_ARRAY, N_COLS_ARRAY, N, F_WIDTH, SEL_WIDTH, NUM_COL_WIDTH) and the state enum wls_state_t.
- One sub-module, pe_index_counter: nested k/c/r counter with enable, programmable k limit, and a last flag.

## Test plan
- fs=3, base=0, L=1 memory returning data = address → 48 load_o pulses. Pulse i carries weight i, with k=i%3, c=(i/3)%4, r=i/12. done_o at cycle 98.
- fs=1, base=1020, L=3 → 16 reads at addresses 1020..1023, then 0..11 (wrap). done_o after the last load.
- filter_size_i=0, then 4 (with N=3) → err_o one-cycle pulse each time, no mem_rd_o, busy_o=0.
- start_i pulsed mid-load, plus a spurious mem_valid_i while in REQ → ignored. Sequence and counts are unchanged.
- rst_i asserted during WAIT at word 20 → all outputs 0 immediately. A fresh start then reloads from word 0 at base.
- Back-to-back starts (start_i held high across done) → second load begins in the cycle after done_o, reading from the newly latched base.
